// File: rtl/fwd_scoreboard_pkg.sv
// Shared types and constants for the forwarding scoreboard.
package fwd_scoreboard_pkg;

  localparam int unsigned FWD_SEL_RF = 0;

  typedef logic [4:0] regbits_t;

  typedef struct packed {
    logic     valid;
    regbits_t wr_addr;
    logic     is_load;
  } fwd_entry_t;

  function automatic int unsigned fwd_sel_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// Issue-side handshake between decode/execute and the forwarding scoreboard.
interface fwd_scoreboard_if #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned DEPTH   = 3,
  parameter int unsigned REG_W   = 5
);
  localparam int unsigned SEL_W = $clog2(DEPTH + 1);

  logic                       advance;
  logic                       flush;
  logic                       issue_valid;
  logic                       issue_wr_en;
  logic [REG_W-1:0]           issue_wr_addr;
  logic                       issue_is_load;
  logic [NUM_SRC*REG_W-1:0]   issue_src_addr;
  logic [NUM_SRC-1:0]         issue_src_used;
  logic [NUM_SRC*SEL_W-1:0]   fwd_sel;
  logic                       stall;
  logic [SEL_W-1:0]           occupancy;

  modport master (
    output advance, flush, issue_valid, issue_wr_en, issue_wr_addr,
           issue_is_load, issue_src_addr, issue_src_used,
    input  fwd_sel, stall, occupancy
  );

  modport slave (
    input  advance, flush, issue_valid, issue_wr_en, issue_wr_addr,
           issue_is_load, issue_src_addr, issue_src_used,
    output fwd_sel, stall, occupancy
  );

endinterface

// File: rtl/fwd_scoreboard_match_lookup.sv
// Priority search of the writer stages for one source operand; youngest stage wins.
module fwd_match_lookup #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned REG_W = 5,
  parameter int unsigned SEL_W = 2
) (
  input  logic [DEPTH-1:0]       ent_valid,
  input  logic [DEPTH*REG_W-1:0] ent_addr,
  input  logic [DEPTH-1:0]       ent_load,
  input  logic [REG_W-1:0]       src_addr,
  input  logic                   src_used,
  output logic                   hit,
  output logic [SEL_W-1:0]       stage,
  output logic                   is_load
);

  always_comb begin
    hit     = 1'b0;
    stage   = '0;
    is_load = 1'b0;
    if (src_used && (src_addr != '0)) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (!hit && ent_valid[k] && (ent_addr[k*REG_W +: REG_W] == src_addr)) begin
          hit     = 1'b1;
          stage   = SEL_W'(k);
          is_load = ent_load[k];
        end
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: DEPTH-stage writer history, per-source forward select, load-use stall.
// Optional FWD_PERF_CNT_EN adds saturating stall_cnt / fwd_cnt outputs.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_SRC          = 2,
  parameter int unsigned DEPTH            = 3,
  parameter int unsigned REG_W            = 5,
  parameter int unsigned LOAD_READY_STAGE = 1
) (
  input  logic              CLK,
  input  logic              nRST,
  fwd_scoreboard_if.slave   bus
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       fwd_cnt
`endif
);

  localparam int unsigned SEL_W = fwd_sel_width(DEPTH);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] wr_addr;
    logic             is_load;
  } entry_t;

  entry_t                 ent [DEPTH];
  logic [DEPTH-1:0]       ent_valid;
  logic [DEPTH*REG_W-1:0] ent_addr;
  logic [DEPTH-1:0]       ent_load;
  logic [NUM_SRC-1:0]     src_hit;
  logic [NUM_SRC-1:0]     src_stall;
  logic [SEL_W-1:0]       occ;
  logic                   stall;
  logic                   cap;

  always_comb begin
    ent_valid = '0;
    ent_addr  = '0;
    ent_load  = '0;
    occ       = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      ent_valid[k]                = ent[k].valid;
      ent_addr[k*REG_W +: REG_W]  = ent[k].wr_addr;
      ent_load[k]                 = ent[k].is_load;
      occ                         = occ + SEL_W'(ent[k].valid);
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic             hit;
    logic             ld;
    logic [SEL_W-1:0] stg;

    fwd_match_lookup #(
      .DEPTH (DEPTH),
      .REG_W (REG_W),
      .SEL_W (SEL_W)
    ) u_lookup (
      .ent_valid (ent_valid),
      .ent_addr  (ent_addr),
      .ent_load  (ent_load),
      .src_addr  (bus.issue_src_addr[i*REG_W +: REG_W]),
      .src_used  (bus.issue_src_used[i]),
      .hit       (hit),
      .stage     (stg),
      .is_load   (ld)
    );

    assign bus.fwd_sel[i*SEL_W +: SEL_W] = hit ? stg + SEL_W'(1) : SEL_W'(FWD_SEL_RF);
    assign src_hit[i]   = hit;
    assign src_stall[i] = hit & ld & (stg < SEL_W'(LOAD_READY_STAGE));
  end

  assign stall         = bus.issue_valid & ~bus.flush & (|src_stall);
  assign cap           = bus.issue_valid & bus.issue_wr_en & (bus.issue_wr_addr != '0)
                       & ~stall & ~bus.flush;
  assign bus.stall     = stall;
  assign bus.occupancy = occ;

  // Lookup reads only the registered entries, so an instruction never matches its own dest.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int unsigned k = 0; k < DEPTH; k++) ent[k] <= '0;
    end else if (bus.advance) begin
      ent[0] <= cap ? '{valid: 1'b1, wr_addr: bus.issue_wr_addr, is_load: bus.issue_is_load}
                    : '0;
      for (int unsigned k = 1; k < DEPTH; k++) ent[k] <= ent[k-1];
    end
  end

`ifdef FWD_PERF_CNT_EN
  localparam int unsigned CNT_W = $clog2(NUM_SRC + 1);

  logic [CNT_W-1:0] n_fwd;
  logic [32:0]      fwd_sum;

  always_comb begin
    n_fwd = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) n_fwd = n_fwd + CNT_W'(src_hit[i]);
    fwd_sum = {1'b0, fwd_cnt} + 33'(n_fwd);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (bus.advance && stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (bus.advance && bus.issue_valid && !stall && !bus.flush)
        fwd_cnt <= fwd_sum[32] ? '1 : fwd_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed scenarios then random issue traffic against a queue model.
module tb_fwd_scoreboard;
  localparam int NS    = 2;
  localparam int DEP   = 3;
  localparam int RW    = 5;
  localparam int LRS   = 1;
  localparam int SW    = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fwd_scoreboard_if #(.NUM_SRC(NS), .DEPTH(DEP), .REG_W(RW)) bus ();

`ifdef FWD_PERF_CNT_EN
  logic [31:0] stall_cnt, fwd_cnt;
  int unsigned m_stall_cnt, m_fwd_cnt;
`endif

  fwd_scoreboard #(
    .NUM_SRC          (NS),
    .DEPTH            (DEP),
    .REG_W            (RW),
    .LOAD_READY_STAGE (LRS)
  ) dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (bus)
`ifdef FWD_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .fwd_cnt   (fwd_cnt)
`endif
  );

  typedef struct {
    bit v;
    int addr;
    bit ld;
  } ment_t;

  ment_t mq[$];
  int    total = 0;
  int    bad   = 0;

  bit cur_a, cur_f, cur_v, cur_we, cur_ld;
  int cur_wa;
  int cur_src [NS];
  bit cur_used [NS];

  int exp_sel [NS];
  bit exp_stall;
  int exp_occ;
  logic [31:0] obs_sel0, obs_sel1, obs_stall, obs_occ;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ment_t e;
    e.v = 0; e.addr = 0; e.ld = 0;
    mq.delete();
    for (int k = 0; k < DEP; k++) mq.push_back(e);
`ifdef FWD_PERF_CNT_EN
    m_stall_cnt = 0;
    m_fwd_cnt   = 0;
`endif
  endtask

  // Youngest valid writer of the source register supplies the data.
  task automatic model_eval();
    exp_stall = 0;
    exp_occ   = 0;
    for (int k = 0; k < DEP; k++) if (mq[k].v) exp_occ++;
    for (int i = 0; i < NS; i++) begin
      exp_sel[i] = 0;
      if (cur_used[i] && cur_src[i] != 0) begin
        for (int k = 0; k < DEP; k++) begin
          if (mq[k].v && mq[k].addr == cur_src[i]) begin
            exp_sel[i] = k + 1;
            if (mq[k].ld && k < LRS) exp_stall = cur_v && !cur_f;
            break;
          end
        end
      end
    end
  endtask

  task automatic model_update();
    ment_t e;
    if (!cur_a) return;
`ifdef FWD_PERF_CNT_EN
    if (exp_stall) m_stall_cnt++;
    if (cur_v && !exp_stall && !cur_f)
      for (int i = 0; i < NS; i++) if (exp_sel[i] != 0) m_fwd_cnt++;
`endif
    e.v    = cur_v && cur_we && cur_wa != 0 && !exp_stall && !cur_f;
    e.addr = e.v ? cur_wa : 0;
    e.ld   = e.v ? cur_ld : 0;
    mq.push_front(e);
    void'(mq.pop_back());
  endtask

  task automatic do_cycle(input bit a, input bit f, input bit v, input bit we, input int wa,
                          input bit ld, input int s0, input bit u0, input int s1, input bit u1);
    cur_a = a; cur_f = f; cur_v = v; cur_we = we; cur_wa = wa; cur_ld = ld;
    cur_src[0] = s0; cur_used[0] = u0; cur_src[1] = s1; cur_used[1] = u1;
    bus.advance        = a;
    bus.flush          = f;
    bus.issue_valid    = v;
    bus.issue_wr_en    = we;
    bus.issue_wr_addr  = RW'(wa);
    bus.issue_is_load  = ld;
    bus.issue_src_addr = {RW'(s1), RW'(s0)};
    bus.issue_src_used = {u1, u0};
    @(negedge clk);
    model_eval();
    obs_sel0  = 32'(bus.fwd_sel[SW-1:0]);
    obs_sel1  = 32'(bus.fwd_sel[2*SW-1:SW]);
    obs_stall = 32'(bus.stall);
    obs_occ   = 32'(bus.occupancy);
    chk("sel0", obs_sel0, 32'(exp_sel[0]));
    chk("sel1", obs_sel1, 32'(exp_sel[1]));
    chk("stall", obs_stall, 32'(exp_stall));
    chk("occupancy", obs_occ, 32'(exp_occ));
    @(posedge clk);
    model_update();
    #1;
`ifdef FWD_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, 32'(m_stall_cnt));
    chk("fwd_cnt", fwd_cnt, 32'(m_fwd_cnt));
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic drain();
    for (int n = 0; n < DEP; n++) do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
`ifdef FWD_PERF_CNT_EN
    logic [31:0] fwd_before;
`endif
    rst_n = 1'b0;
    bus.advance = 0; bus.flush = 0; bus.issue_valid = 0; bus.issue_wr_en = 0;
    bus.issue_wr_addr = '0; bus.issue_is_load = 0; bus.issue_src_addr = '0;
    bus.issue_src_used = '0;
    model_reset();
    @(posedge clk);
    do_reset();

    // Reset state
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_occ", obs_occ, 0);
    chk("rst_stall", obs_stall, 0);

    // Reset mid-run with three live entries
    do_cycle(1, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    do_cycle(1, 0, 1, 1, 2, 0, 0, 0, 0, 0);
    do_cycle(1, 0, 1, 1, 3, 0, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 0, 0, 3, 1, 2, 1);
    chk("full_occ", obs_occ, 3);
    chk("full_sel0", obs_sel0, 1);
    do_reset();
    do_cycle(0, 0, 1, 0, 0, 0, 3, 1, 2, 1);
    chk("midrst_occ", obs_occ, 0);
    chk("midrst_sel0", obs_sel0, 0);
    chk("midrst_sel1", obs_sel1, 0);

    // ALU chain on $3
    do_cycle(1, 0, 1, 1, 3, 0, 0, 0, 0, 0);
    do_cycle(1, 0, 1, 0, 0, 0, 3, 1, 0, 0);
    chk("alu_s0", obs_sel0, 1);
    do_cycle(1, 0, 1, 0, 0, 0, 3, 1, 0, 0);
    chk("alu_s1", obs_sel0, 2);
    do_cycle(1, 0, 1, 0, 0, 0, 3, 1, 0, 0);
    chk("alu_s2", obs_sel0, 3);
    do_cycle(1, 0, 1, 0, 0, 0, 3, 1, 0, 0);
    chk("alu_retired", obs_sel0, 0);

    // Youngest writer wins
    do_cycle(1, 0, 1, 1, 5, 0, 0, 0, 0, 0);
    do_cycle(1, 0, 1, 1, 6, 0, 0, 0, 0, 0);
    do_cycle(1, 0, 1, 1, 5, 0, 0, 0, 0, 0);
    do_cycle(0, 0, 1, 0, 0, 0, 6, 1, 5, 1);
    chk("young_sel1", obs_sel1, 1);
    chk("young_sel0", obs_sel0, 2);

    // Load-use stall then forward from stage 1
    drain();
    do_cycle(1, 0, 1, 1, 8, 1, 0, 0, 0, 0);
    do_cycle(1, 0, 1, 1, 9, 0, 8, 1, 0, 0);
    chk("lu_stall", obs_stall, 1);
    do_cycle(1, 0, 1, 1, 9, 0, 8, 1, 0, 0);
    chk("lu_clear", obs_stall, 0);
    chk("lu_sel0", obs_sel0, 2);

    // Frozen pipeline ignores issue and flush
    for (int n = 0; n < 4; n++) begin
      do_cycle(0, n[0], 1, 1, 10, 0, 9, 1, 8, 1);
      chk("frz_sel0", obs_sel0, 1);
      chk("frz_occ", obs_occ, 2);
    end
    do_cycle(1, 1, 1, 1, 11, 0, 0, 0, 0, 0);
    do_cycle(0, 0, 1, 0, 0, 0, 11, 1, 9, 1);
    chk("flush_sel0", obs_sel0, 0);
    chk("flush_sel1", obs_sel1, 2);

    // Own destination is invisible to its own sources
    drain();
    do_cycle(1, 0, 1, 1, 4, 0, 4, 1, 0, 0);
    chk("self_sel0", obs_sel0, 0);
    do_cycle(0, 0, 1, 0, 0, 0, 4, 1, 0, 0);
    chk("self_next", obs_sel0, 1);

    // $0 never captured nor forwarded
    drain();
`ifdef FWD_PERF_CNT_EN
    fwd_before = fwd_cnt;
`endif
    do_cycle(1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    do_cycle(1, 0, 1, 0, 0, 0, 0, 1, 0, 1);
    chk("r0_sel0", obs_sel0, 0);
    chk("r0_occ", obs_occ, 0);
`ifdef FWD_PERF_CNT_EN
    chk("r0_fwdcnt", fwd_cnt, fwd_before);
`endif

    // Random traffic over a small register set
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(63) == 0) do_reset();
      do_cycle($urandom_range(9) < 8, $urandom_range(9) == 0, $urandom_range(4) != 0,
               $urandom_range(3) != 0, int'($urandom_range(7)), $urandom_range(2) == 0,
               int'($urandom_range(7)), $urandom_range(4) != 0,
               int'($urandom_range(7)), $urandom_range(4) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised, stateful successor to the combinational bus A/B forwarding logic.
- Keeps a DEPTH-stage shift register of in-flight register writers. It produces a per-source forwarding select for NUM_SRC read operands and a load-use stall.
- Sits beside decode/execute. The datapath muxes operands from the register file or from any tracked stage's result bus, according to fwd_sel.

Parameters:
- NUM_SRC, 2, number of source operands checked per issued instruction.
- DEPTH, 3, number of tracked writer stages (stage 0 = youngest, nearest execute).
- REG_W, 5, register address width.
- LOAD_READY_STAGE, 1, first stage index at which a load's data may be forwarded; 0 < LOAD_READY_STAGE < DEPTH.

Ports:
- CLK  in  1  clock.
- nRST  in  1  synchronous active-low reset.
- advance  in  1  pipeline moves this cycle (ihit/dhit combined); 0 freezes all state.
- flush  in  1  squash the instruction presented on issue_*.
- issue_valid  in  1  an instruction is presented for issue.
- issue_wr_en  in  1  the presented instruction writes a register.
- issue_wr_addr  in  REG_W  destination register.
- issue_is_load  in  1  destination is written from memory.
- issue_src_addr  in  NUM_SRC*REG_W  source registers, src i at [i*REG_W +: REG_W].
- issue_src_used  in  NUM_SRC  source i is actually read.
- fwd_sel  out  NUM_SRC*SEL_W  per-source select. SEL_W = $clog2(DEPTH+1). 0 = register file; k+1 = stage k result.
- stall  out  1  load-use hazard; hold the issuing instruction.
- occupancy  out  $clog2(DEPTH+1)  count of valid entries.

Behaviour:
- Entry state, per stage k: valid, wr_addr, is_load. All registered.
- Reset: on a CLK edge with nRST=0, all valid <= 0. Consequently fwd_sel = 0, stall = 0, occupancy = 0.
- Reset has priority over advance and flush, including mid-operation.
- Capture condition: cap = issue_valid & issue_wr_en & (issue_wr_addr != 0) & !stall & !flush.
- On an edge with advance=1:
  - entry[k] <= entry[k-1] for k = 1..DEPTH-1;
  - entry[0] <= cap ? {1, issue_wr_addr, issue_is_load} : bubble (valid=0);
  - entry[DEPTH-1] retires.
- On an edge with advance=0: all entries hold. Flush and issue are ignored.
- Source lookup (combinational from registered state plus issue inputs):
  - The match for src i considers only valid entries with wr_addr == src_addr[i].
  - It applies only when src_addr[i] != 0 and issue_src_used[i] = 1.
  - The youngest (lowest k) match wins; fwd_sel_i = k+1. No match gives 0.
  - Register 0 is never forwarded.
- Stall: stall = issue_valid & !flush & OR over i of (the youngest match is_load AND k < LOAD_READY_STAGE).
  - fwd_sel is still driven while stall=1. The datapath ignores it.
- Stalled cycle with advance=1: older entries shift; stage 0 receives a bubble. The hazard clears after (LOAD_READY_STAGE - k) advancing cycles.
- Simultaneous events:
  - Issue with flush: flush wins; a bubble is inserted.
  - Issue of an instruction whose dest equals its own source: it sees only older entries, never itself.
- Occupancy: popcount of valid, updated with state.
- Latency: fwd_sel/stall are zero-cycle (same cycle as issue_*). An entry becomes visible one edge after capture.

Optional Feature:
- Macro: FWD_PERF_CNT_EN.
- When defined:
  - adds outputs stall_cnt[31:0] and fwd_cnt[31:0];
  - stall_cnt increments on each edge with advance & stall;
  - fwd_cnt increments by the number of sources with fwd_sel != 0 on edges with advance & issue_valid & !stall & !flush;
  - both saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined: no counters, no extra ports, identical functional behaviour otherwise.

Decomposition:
- my_types_pkg additions:
  - fwd_entry_t packed struct {valid, wr_addr, is_load};
  - constant FWD_SEL_RF = 0.
- cpu_types_pkg regbits_t is used when REG_W = 5.
- Sub-module fwd_match_lookup: combinational priority search of the entry array for one source. It returns {hit, stage index, is_load}. It is instantiated NUM_SRC times via generate.

Test Plan:
- Reset mid-run: fill 3 entries, pulse nRST=0 for one edge -> occupancy=0, fwd_sel=0, stall=0 next cycle.
- ALU chain: issue add $3; next cycle issue src0=$3 -> fwd_sel0=1. Two advances later -> fwd_sel0=3. After 3 advances -> 0.
- Youngest wins: writers to $5 in stages 0 and 2; src1=$5 -> fwd_sel1=1.
- Load-use: lw $8, then issue src0=$8 -> stall=1 for one advancing cycle. Bubble inserted, then fwd_sel0=2 with stall=0.
- Freeze/flush: advance=0 with issue and flush toggling for 4 cycles -> entries unchanged. Flush with advance=1 -> stage 0 valid=0.
- $0 handling: issue with wr_addr=0, then src=$0 -> never captured, fwd_sel=0. With FWD_PERF_CNT_EN, fwd_cnt unchanged.
